coeff_mac_stage: RTL and testbench
==================================

Name: coeff_mac_stage

Overview:
- Sits directly downstream of the delay/sum stage and consumes its `mult_1` data word, qualified by its `delay_o` strobe.
- Multiplies each accepted word by a programmable Q16.16 coefficient chosen by `coeff_sel`.
- Accumulates the products and returns a one-cycle `srdyo` pulse; upstream control uses that pulse as `srdyi_i`.
- Honours the upstream `clk_stop` freeze.

Parameters:
- DATA_W, 32, data/coefficient/accumulator width (signed two's complement)
- FRAC_W, 16, fractional bits (Q16.16 format)
- N_COEFF, 8, coefficient table depth; selector width is log2(N_COEFF) = 3

Ports:
- clk  in  1  system clock, all state on rising edge
- GlobalReset_n  in  1  reset, asynchronous, active-low
- mult_i  in  32  signed Q16.16 operand (from upstream `mult_1`)
- delay_i  in  1  operand strobe (from upstream `delay_o`); rising edge = new operand
- coeff_sel  in  3  coefficient index used at operand latch
- coeff_wr_en  in  1  coefficient table write enable
- coeff_wr_addr  in  3  coefficient write index
- coeff_wr_data  in  32  coefficient write value, Q16.16
- acc_clr  in  1  synchronous accumulator clear
- clk_stop  in  1  freeze request (from upstream `clk_stop`)
- product_o  out  32  last truncated product, Q16.16
- acc_o  out  32  accumulator, Q16.16
- srdyo  out  1  one-cycle pulse, result valid
- busy  out  1  high when FSM is not IDLE
- miss  out  1  sticky: strobe edge arrived while busy
- ovf  out  1  sticky: accumulator overflow (ACC_SAT_EN only)

Behaviour:
- Reset (GlobalReset_n = 0, async):
  - product_o, acc_o, srdyo, busy, miss, ovf, and the edge-detect register are all 0.
  - FSM goes to IDLE.
  - All coefficient entries are set to 32'h0001_0000 (1.0).
- Edge detect: `edge = delay_i & ~delay_q`. delay_q updates every cycle, including while clk_stop is high. A level held for many cycles produces exactly one edge.
- FSM states: IDLE -> MUL -> ACC -> DONE -> IDLE.
  - IDLE: on edge with clk_stop = 0, latch op_q <= mult_i and cf_q <= coeff[coeff_sel], then go to MUL.
  - MUL: prod64 = signed op_q * signed cf_q. Register prod_q <= prod64[47:16] (truncation, wraps).
  - ACC: acc_o <= acc_o + prod_q; product_o <= prod_q.
  - DONE: srdyo = 1 for exactly this cycle, then IDLE.
- Latency: edge sampled at cycle N gives srdyo high at cycle N+3. Minimum operand spacing is 4 cycles.
- Edge while busy: the operand is ignored, miss is set, and the current operation is unaffected. miss clears only on reset.
- clk_stop = 1:
  - FSM state, op_q, cf_q, prod_q and acc_o hold.
  - srdyo is forced to 0; a DONE frozen by clk_stop pulses srdyo after release.
  - Edges during the stop are ignored; miss is not set.
- acc_clr:
  - In any non-ACC cycle: acc_o <= 0.
  - In the ACC cycle: acc_o <= prod_q (clear then add).
  - acc_clr does not clear product_o.
  - acc_clr is ignored while clk_stop = 1.
- Coefficient writes:
  - Always accepted, including when busy or stopped.
  - A write and a latch to the same index in the same cycle latches the old value; the new value is visible from the next cycle.
- Reset asserted mid-operation: all state returns to reset values immediately and the in-flight operand is lost, with no srdyo.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined:
  - ACC computes the sum at 33 bits.
  - Signed overflow saturates acc_o to 32'h7FFF_FFFF; underflow saturates it to 32'h8000_0000.
  - ovf becomes sticky 1.
- Undefined:
  - The accumulator wraps modulo 2^32.
  - ovf is tied to 0.

Decomposition:
- Shared package dsp_pkg holds:
  - DATA_W, FRAC_W and N_COEFF;
  - ONE_Q16 = 32'h0001_0000;
  - SAT_MAX / SAT_MIN constants;
  - the FSM state enum (IDLE, MUL, ACC, DONE).
- One sub-module: coeff_bank, the N_COEFF x DATA_W register file. It has an async active-low reset to ONE_Q16, one synchronous write port, and one combinational read port.

Test Plan:
- Reset, mult_i = 32'h0002_0000, single delay_i pulse -> srdyo exactly 3 cycles after the sampled edge; product_o = acc_o = 32'h0002_0000.
- Write coeff[3] = 32'h0000_8000, coeff_sel = 3, mult_i = 32'h0006_0000, then a second op with mult_i = 32'hFFFE_0000 -> product_o = 32'h0003_0000 then 32'hFFFF_0000; acc_o = 32'h0002_0000.
- delay_i held high 10 cycles, then a second edge 1 cycle after the first op's srdyo -> exactly two srdyo pulses and miss = 0. A further edge 2 cycles after an accepted edge -> ignored and miss = 1.
- clk_stop raised during MUL for 5 cycles -> acc_o, busy and FSM state hold; srdyo appears 5 cycles later than nominal.
- acc_o = 32'h7FFF_0000, then add product 32'h0002_0000:
  - with ACC_SAT_EN: acc_o = 32'h7FFF_FFFF and ovf = 1;
  - without it: acc_o = 32'h8001_0000 and ovf = 0.
- GlobalReset_n pulsed low during ACC and acc_clr asserted in ACC -> reset gives all outputs 0, no srdyo and coeff = ONE_Q16; clear in ACC gives acc_o = prod_q.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants, FSM state type and the Q16.16 multiply helper for the
// coefficient MAC stage.
package dsp_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FRAC_W  = 16;
  localparam int unsigned N_COEFF = 8;
  localparam int unsigned SEL_W   = $clog2(N_COEFF);

  localparam logic [DATA_W-1:0] ONE_Q16 = 32'h0001_0000;
  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC,
    DONE
  } state_t;

  // Full-precision signed product, then keep the Q16.16 window (wraps on overflow).
  function automatic logic [DATA_W-1:0] q_mul(input logic signed [DATA_W-1:0] a,
                                              input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    return p[FRAC_W +: DATA_W];
  endfunction

endpackage

// File: rtl/coeff_mac_stage_if.sv
// Signal bundle between the upstream delay/sum control and the MAC stage.
interface coeff_mac_stage_if;
  import dsp_pkg::*;

  logic [DATA_W-1:0] mult_i;
  logic              delay_i;
  logic [SEL_W-1:0]  coeff_sel;
  logic              coeff_wr_en;
  logic [SEL_W-1:0]  coeff_wr_addr;
  logic [DATA_W-1:0] coeff_wr_data;
  logic              acc_clr;
  logic              clk_stop;
  logic [DATA_W-1:0] product_o;
  logic [DATA_W-1:0] acc_o;
  logic              srdyo;
  logic              busy;
  logic              miss;
  logic              ovf;

  modport master (
    output mult_i, delay_i, coeff_sel, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
           acc_clr, clk_stop,
    input  product_o, acc_o, srdyo, busy, miss, ovf
  );

  modport slave (
    input  mult_i, delay_i, coeff_sel, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
           acc_clr, clk_stop,
    output product_o, acc_o, srdyo, busy, miss, ovf
  );

endinterface

// File: rtl/coeff_bank.sv
// N_COEFF x DATA_W coefficient register file: resets to 1.0, one synchronous
// write port and one combinational read port.
module coeff_bank
  import dsp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [N_COEFF];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_COEFF; i++) begin
        mem[i] <= ONE_Q16;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Reads see the pre-write value in the write cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/coeff_mac_stage.sv
// Q16.16 coefficient multiply-accumulate stage fed by the delay/sum strobe.
// Build option: define ACC_SAT_EN for a saturating accumulator with sticky ovf.
module coeff_mac_stage
  import dsp_pkg::*;
(
  input  logic             clk,
  input  logic             GlobalReset_n,
  coeff_mac_stage_if.slave bus
);

  state_t            state_q, state_d;
  logic              delay_q;
  logic              strobe_edge;
  logic [DATA_W-1:0] op_q, cf_q, prod_q, acc_q, product_q;
  logic [DATA_W-1:0] cf_rd;
  logic [DATA_W-1:0] acc_base, acc_sum;
  logic              miss_q;
  logic              busy_c, srdyo_c;
`ifdef ACC_SAT_EN
  logic [DATA_W:0]   sum_ext;
  logic              ovf_hit;
  logic              ovf_q;
`endif

  coeff_bank u_bank (
    .clk     (clk),
    .rst_n   (GlobalReset_n),
    .wr_en   (bus.coeff_wr_en),
    .wr_addr (bus.coeff_wr_addr),
    .wr_data (bus.coeff_wr_data),
    .rd_addr (bus.coeff_sel),
    .rd_data (cf_rd)
  );

  assign strobe_edge = bus.delay_i & ~delay_q;

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.clk_stop) begin
      unique case (state_q)
        IDLE: if (strobe_edge) state_d = MUL;
        MUL:  state_d = ACC;
        ACC:  state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_c  = (state_q != IDLE);
    srdyo_c = (state_q == DONE) && !bus.clk_stop;
  end

  // Clear-then-add when acc_clr coincides with the ACC cycle.
  always_comb begin
    acc_base = bus.acc_clr ? '0 : acc_q;
    acc_sum  = acc_base + prod_q;
`ifdef ACC_SAT_EN
    sum_ext  = {acc_base[DATA_W-1], acc_base} + {prod_q[DATA_W-1], prod_q};
    ovf_hit  = 1'b0;
    if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
      ovf_hit = 1'b1;
      acc_sum = sum_ext[DATA_W] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      delay_q   <= 1'b0;
      op_q      <= '0;
      cf_q      <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
      miss_q    <= 1'b0;
`ifdef ACC_SAT_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      delay_q <= bus.delay_i;
      if (!bus.clk_stop) begin
        if (strobe_edge && state_q == IDLE) begin
          op_q <= bus.mult_i;
          cf_q <= cf_rd;
        end
        if (strobe_edge && state_q != IDLE) begin
          miss_q <= 1'b1;
        end
        if (state_q == MUL) begin
          prod_q <= q_mul(op_q, cf_q);
        end
        if (state_q == ACC) begin
          acc_q     <= acc_sum;
          product_q <= prod_q;
`ifdef ACC_SAT_EN
          if (ovf_hit) ovf_q <= 1'b1;
`endif
        end else if (bus.acc_clr) begin
          acc_q <= '0;
        end
      end
    end
  end

  assign bus.product_o = product_q;
  assign bus.acc_o     = acc_q;
  assign bus.srdyo     = srdyo_c;
  assign bus.busy      = busy_c;
  assign bus.miss      = miss_q;
`ifdef ACC_SAT_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_coeff_mac_stage.sv
// Directed self-checking bench for coeff_mac_stage.
module tb_coeff_mac_stage;
  import dsp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;

  always #5 clk = ~clk;

  coeff_mac_stage_if mif ();

  coeff_mac_stage dut (
    .clk           (clk),
    .GlobalReset_n (rst_n),
    .bus           (mif)
  );

  always @(negedge clk) if (mif.srdyo === 1'b1) pulses++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] m, input logic [2:0] sel, output int lat);
    mif.mult_i    = m;
    mif.coeff_sel = sel;
    mif.delay_i   = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) mif.delay_i = 1'b0;
      if (mif.srdyo === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic clear_acc;
    mif.acc_clr = 1'b1;
    tick();
    mif.acc_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if (mif.product_o !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=%h", mif.product_o, 32'h0); end
    checks++; if (mif.acc_o !== 32'h0) begin errors++; $display("FAIL reset_acc got=%h exp=%h", mif.acc_o, 32'h0); end
    checks++; if ({mif.srdyo, mif.busy, mif.miss, mif.ovf} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=%b", {mif.srdyo, mif.busy, mif.miss, mif.ovf}, 4'b0000); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    int lat;
    int p0;
    p0 = pulses;
    run_op(32'h0002_0000, 3'd0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, 3); end
    checks++; if (mif.product_o !== 32'h0002_0000) begin errors++; $display("FAIL single_product got=%h exp=%h", mif.product_o, 32'h0002_0000); end
    checks++; if (mif.acc_o !== 32'h0002_0000) begin errors++; $display("FAIL single_acc got=%h exp=%h", mif.acc_o, 32'h0002_0000); end
    tick();
    checks++; if ({mif.srdyo, mif.busy} !== 2'b00) begin errors++; $display("FAIL single_idle got=%b exp=%b", {mif.srdyo, mif.busy}, 2'b00); end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL single_pulses got=%0d exp=%0d", pulses - p0, 1); end
  endtask

  task automatic test_coeff_write;
    int lat;
    clear_acc();
    checks++; if (mif.acc_o !== 32'h0) begin errors++; $display("FAIL clr_acc got=%h exp=%h", mif.acc_o, 32'h0); end
    checks++; if (mif.product_o !== 32'h0002_0000) begin errors++; $display("FAIL clr_keeps_product got=%h exp=%h", mif.product_o, 32'h0002_0000); end
    mif.coeff_wr_en = 1'b1; mif.coeff_wr_addr = 3'd3; mif.coeff_wr_data = 32'h0000_8000;
    tick();
    mif.coeff_wr_en = 1'b0;
    run_op(32'h0006_0000, 3'd3, lat);
    checks++; if (mif.product_o !== 32'h0003_0000) begin errors++; $display("FAIL half_pos_product got=%h exp=%h", mif.product_o, 32'h0003_0000); end
    tick();
    run_op(32'hFFFE_0000, 3'd3, lat);
    checks++; if (mif.product_o !== 32'hFFFF_0000) begin errors++; $display("FAIL half_neg_product got=%h exp=%h", mif.product_o, 32'hFFFF_0000); end
    checks++; if (mif.acc_o !== 32'h0002_0000) begin errors++; $display("FAIL half_acc got=%h exp=%h", mif.acc_o, 32'h0002_0000); end
    tick();
    // write and latch of index 5 in the same cycle: old value (1.0) used
    mif.coeff_wr_en = 1'b1; mif.coeff_wr_addr = 3'd5; mif.coeff_wr_data = 32'h0003_0000;
    mif.mult_i = 32'h0001_0000; mif.coeff_sel = 3'd5; mif.delay_i = 1'b1;
    tick();
    mif.coeff_wr_en = 1'b0; mif.delay_i = 1'b0;
    tick();
    tick();
    checks++; if (mif.srdyo !== 1'b1) begin errors++; $display("FAIL wr_latch_srdyo got=%b exp=%b", mif.srdyo, 1'b1); end
    checks++; if (mif.product_o !== 32'h0001_0000) begin errors++; $display("FAIL wr_latch_old got=%h exp=%h", mif.product_o, 32'h0001_0000); end
    tick();
    run_op(32'h0001_0000, 3'd5, lat);
    checks++; if (mif.product_o !== 32'h0003_0000) begin errors++; $display("FAIL wr_latch_new got=%h exp=%h", mif.product_o, 32'h0003_0000); end
    checks++; if (mif.acc_o !== 32'h0006_0000) begin errors++; $display("FAIL wr_latch_acc got=%h exp=%h", mif.acc_o, 32'h0006_0000); end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    int p0;
    p0 = pulses;
    mif.mult_i = 32'h0001_0000; mif.coeff_sel = 3'd0; mif.delay_i = 1'b1;
    repeat (10) tick();
    mif.delay_i = 1'b0;
    tick();
    tick();
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL held_pulses got=%0d exp=%0d", pulses - p0, 1); end
    run_op(32'h0001_0000, 3'd0, lat1);
    tick();
    run_op(32'h0002_0000, 3'd0, lat2);
    checks++; if (lat1 !== 3) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=%0d", lat1, 3); end
    checks++; if (lat2 !== 3) begin errors++; $display("FAIL b2b_lat2 got=%0d exp=%0d", lat2, 3); end
    tick();
    checks++; if (pulses - p0 !== 3) begin errors++; $display("FAIL b2b_pulses got=%0d exp=%0d", pulses - p0, 3); end
    checks++; if (mif.miss !== 1'b0) begin errors++; $display("FAIL b2b_miss got=%b exp=%b", mif.miss, 1'b0); end
    checks++; if (mif.acc_o !== 32'h000A_0000) begin errors++; $display("FAIL b2b_acc got=%h exp=%h", mif.acc_o, 32'h000A_0000); end
  endtask

  task automatic test_clk_stop;
    int lat;
    int p0;
    int stop_err;
    p0 = pulses;
    stop_err = 0;
    lat = 0;
    mif.mult_i = 32'h0004_0000; mif.coeff_sel = 3'd0; mif.delay_i = 1'b1;
    tick();
    mif.delay_i = 1'b0;
    mif.clk_stop = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      mif.delay_i = (i == 2);
      mif.acc_clr = (i == 3);
      tick();
      if (mif.busy !== 1'b1 || mif.srdyo !== 1'b0 || mif.acc_o !== 32'h000A_0000) stop_err++;
    end
    checks++; if (stop_err !== 0) begin errors++; $display("FAIL stop_hold got=%0d bad cycles exp=%0d", stop_err, 0); end
    mif.clk_stop = 1'b0; mif.delay_i = 1'b0; mif.acc_clr = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (mif.srdyo === 1'b1) begin
        lat = 6 + i;
        break;
      end
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL stop_latency got=%0d exp=%0d", lat, 8); end
    checks++; if (mif.acc_o !== 32'h000E_0000) begin errors++; $display("FAIL stop_acc got=%h exp=%h", mif.acc_o, 32'h000E_0000); end
    checks++; if (mif.miss !== 1'b0) begin errors++; $display("FAIL stop_miss got=%b exp=%b", mif.miss, 1'b0); end
    tick();
    // freeze while in DONE
    mif.mult_i = 32'h0001_0000; mif.delay_i = 1'b1;
    tick();
    mif.delay_i = 1'b0;
    tick();
    tick();
    mif.clk_stop = 1'b1;
    #1;
    checks++; if (mif.srdyo !== 1'b0) begin errors++; $display("FAIL done_frozen_srdyo got=%b exp=%b", mif.srdyo, 1'b0); end
    tick();
    tick();
    checks++; if ({mif.busy, mif.srdyo} !== 2'b10) begin errors++; $display("FAIL done_frozen_state got=%b exp=%b", {mif.busy, mif.srdyo}, 2'b10); end
    mif.clk_stop = 1'b0;
    #1;
    checks++; if (mif.srdyo !== 1'b1) begin errors++; $display("FAIL done_release_srdyo got=%b exp=%b", mif.srdyo, 1'b1); end
    tick();
    checks++; if (pulses - p0 !== 2) begin errors++; $display("FAIL stop_pulses got=%0d exp=%0d", pulses - p0, 2); end
  endtask

  task automatic test_miss;
    int p0;
    p0 = pulses;
    mif.mult_i = 32'h0003_0000; mif.coeff_sel = 3'd0; mif.delay_i = 1'b1;
    tick();
    mif.delay_i = 1'b0;
    tick();
    mif.delay_i = 1'b1; mif.mult_i = 32'h0007_0000;
    tick();
    checks++; if (mif.srdyo !== 1'b1) begin errors++; $display("FAIL miss_srdyo got=%b exp=%b", mif.srdyo, 1'b1); end
    checks++; if (mif.miss !== 1'b1) begin errors++; $display("FAIL miss_flag got=%b exp=%b", mif.miss, 1'b1); end
    checks++; if (mif.product_o !== 32'h0003_0000) begin errors++; $display("FAIL miss_product got=%h exp=%h", mif.product_o, 32'h0003_0000); end
    mif.delay_i = 1'b0;
    repeat (4) tick();
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL miss_pulses got=%0d exp=%0d", pulses - p0, 1); end
    checks++; if (mif.acc_o !== 32'h0012_0000) begin errors++; $display("FAIL miss_acc got=%h exp=%h", mif.acc_o, 32'h0012_0000); end
  endtask

  task automatic test_saturation;
    int lat;
    logic [31:0] exp_acc;
    logic        exp_ovf;
`ifdef ACC_SAT_EN
    exp_acc = 32'h7FFF_FFFF; exp_ovf = 1'b1;
`else
    exp_acc = 32'h8001_0000; exp_ovf = 1'b0;
`endif
    clear_acc();
    checks++; if (mif.ovf !== 1'b0) begin errors++; $display("FAIL ovf_initial got=%b exp=%b", mif.ovf, 1'b0); end
    run_op(32'h7FFF_0000, 3'd0, lat);
    checks++; if (mif.acc_o !== 32'h7FFF_0000) begin errors++; $display("FAIL sat_pre_acc got=%h exp=%h", mif.acc_o, 32'h7FFF_0000); end
    tick();
    run_op(32'h0002_0000, 3'd0, lat);
    checks++; if (mif.acc_o !== exp_acc) begin errors++; $display("FAIL sat_acc got=%h exp=%h", mif.acc_o, exp_acc); end
    checks++; if (mif.ovf !== exp_ovf) begin errors++; $display("FAIL sat_ovf got=%b exp=%b", mif.ovf, exp_ovf); end
    tick();
  endtask

  task automatic test_acc_clr_in_acc;
    mif.mult_i = 32'h0003_0000; mif.coeff_sel = 3'd0; mif.delay_i = 1'b1;
    tick();
    mif.delay_i = 1'b0;
    tick();
    mif.acc_clr = 1'b1;
    tick();
    mif.acc_clr = 1'b0;
    checks++; if (mif.srdyo !== 1'b1) begin errors++; $display("FAIL clr_acc_srdyo got=%b exp=%b", mif.srdyo, 1'b1); end
    checks++; if (mif.acc_o !== 32'h0003_0000) begin errors++; $display("FAIL clr_in_acc got=%h exp=%h", mif.acc_o, 32'h0003_0000); end
    tick();
    clear_acc();
    checks++; if ({mif.acc_o, mif.product_o} !== {32'h0, 32'h0003_0000}) begin errors++; $display("FAIL clr_idle got=%h_%h exp=%h_%h", mif.acc_o, mif.product_o, 32'h0, 32'h0003_0000); end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    int p0;
    mif.coeff_wr_en = 1'b1; mif.coeff_wr_addr = 3'd2; mif.coeff_wr_data = 32'h0002_0000;
    tick();
    mif.coeff_wr_en = 1'b0;
    p0 = pulses;
    mif.mult_i = 32'h0005_0000; mif.coeff_sel = 3'd2; mif.delay_i = 1'b1;
    tick();
    mif.delay_i = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({mif.product_o, mif.acc_o} !== 64'h0) begin errors++; $display("FAIL rst_mid_data got=%h_%h exp=0_0", mif.product_o, mif.acc_o); end
    checks++; if ({mif.srdyo, mif.busy, mif.miss, mif.ovf} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got=%b exp=%b", {mif.srdyo, mif.busy, mif.miss, mif.ovf}, 4'b0000); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL rst_mid_pulses got=%0d exp=%0d", pulses - p0, 0); end
    run_op(32'h0001_0000, 3'd2, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rst_post_latency got=%0d exp=%0d", lat, 3); end
    checks++; if (mif.product_o !== 32'h0001_0000) begin errors++; $display("FAIL rst_coeff_one got=%h exp=%h", mif.product_o, 32'h0001_0000); end
    checks++; if (mif.acc_o !== 32'h0001_0000) begin errors++; $display("FAIL rst_post_acc got=%h exp=%h", mif.acc_o, 32'h0001_0000); end
    tick();
  endtask

  initial begin
    mif.mult_i = '0; mif.delay_i = 1'b0; mif.coeff_sel = '0;
    mif.coeff_wr_en = 1'b0; mif.coeff_wr_addr = '0; mif.coeff_wr_data = '0;
    mif.acc_clr = 1'b0; mif.clk_stop = 1'b0;
    test_reset();
    test_single();
    test_coeff_write();
    test_back_to_back();
    test_clk_stop();
    test_miss();
    test_saturation();
    test_acc_clr_in_acc();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
